fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
Fetch-stage front end that owns the architectural fetch PC and sits directly upstream of the tournament branch predictor. Each cycle it presents its PC to the predictor and issues one instruction-memory read. On each memory response it takes the predictor's next PC and pushes a fetch packet (instruction, PC, prediction) into a small queue. The queue feeds the IF/ID latch. Resolution-stage redirects flush the queue and discard any in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
FQ_DEPTH, 2, fetch-queue entries; must be a power of two and at least 2.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
imem_ren  out  1  instruction read request
imem_addr  out  32  read address; word-aligned; stable while imem_ren is high
imem_ihit  in  1  read complete this cycle
imem_rdata  in  32  instruction word, valid with imem_ihit
pc_fetch  out  32  current fetch PC, driven to the predictor
pred_nxt_pc  in  32  predictor next PC for pc_fetch, combinational
redirect  in  1  mispredict or flush from resolution
redirect_pc  in  32  correct PC, valid with redirect
dec_stall  in  1  decode cannot accept the head packet
ifid_valid  out  1  head packet valid
ifid_instr  out  32  head instruction
ifid_pc  out  32  head PC
ifid_pred_taken  out  1  head predicted taken
ifid_pred_target  out  32  head predicted next PC

Behaviour:
- Reset (async, active-high):
  - pc = RESET_PC; queue empty; state RUN.
  - All ifid_* outputs = 0.
  - imem_ren is forced to 0 while RST is high.
- State RUN:
  - imem_ren = (count < FQ_DEPTH).
  - imem_addr = pc_fetch = pc.
- State DRAIN:
  - imem_ren = 1 and imem_addr = stale request address (drain_addr) until imem_ihit.
  - Any response received is discarded.
  - pc_fetch = pc, already redirected.
- Issue rule: once imem_ren rises with an address, both signals hold until imem_ihit. There is one outstanding request at most. The count only rises on ihit, so a request is never withdrawn.
- Accepted response (RUN, imem_ihit, no redirect):
  - Push {imem_rdata, pc, pred_taken = (pred_nxt_pc != pc + 4), pred_target = pred_nxt_pc}.
  - Then pc <= pred_nxt_pc.
  - pc + 4 wraps modulo 2^32.
- Pop: when ifid_valid && !dec_stall. The head shows combinationally from the queue, so there is zero-cycle visibility after a push registers. Latency is ihit cycle + 1 to ifid_valid.
- Simultaneous push and pop while full:
  - Not possible, because no request is outstanding when full.
  - Push and pop at count == 1 leave the count unchanged.
- Redirect (highest priority, any state):
  - Queue cleared (count = 0, ifid_valid = 0 next cycle).
  - pc <= redirect_pc.
  - If a request is outstanding and imem_ihit == 0 this cycle: drain_addr <= old address, next state DRAIN.
  - If imem_ihit == 1 this cycle: the response is dropped and the next state is RUN.
  - Redirect while in DRAIN: pc updated again; stay in DRAIN.
- DRAIN -> RUN on imem_ihit, with the response discarded. A new request to pc may start the following cycle.
- Misaligned redirect_pc: bits [1:0] are forced to 0.
- The queue is a circular buffer. Pointers are log2(FQ_DEPTH) bits and wrap naturally; count is log2(FQ_DEPTH)+1 bits.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds outputs perf_redirects (32) and perf_stall_cycles (32).
  - perf_redirects counts redirect cycles.
  - perf_stall_cycles counts cycles with ifid_valid && dec_stall.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: neither port nor counter exists; functional behaviour is identical.

Decomposition:
- fetch_pkg (shared package):
  - fetch_state_t enum {RUN, DRAIN}.
  - fetch_packet_t struct {instr, pc, pred_taken, pred_target}.
  - Constant PC_STEP = 32'd4.
- Sub-module fetch_queue: parameterised FIFO of fetch_packet_t with push, pop, flush, full, empty and a head port.

Test Plan:
- Reset release, RESET_PC = 0, ihit one cycle after ren, pred_nxt_pc = pc + 4, no stall -> imem_addr 0, 4, 8 on consecutive requests; ifid_pc 0, 4, 8 with ifid_pred_taken = 0.
- pc = 0x40, pred_nxt_pc = 0x100 -> packet {pc 0x40, pred_taken 1, pred_target 0x100}; next imem_addr = 0x100.
- dec_stall held high for 5 cycles -> queue fills to 2; imem_ren = 0; after stall drops, the head pops and imem_ren reasserts with no lost or duplicated packet.
- Redirect to 0x200 while a request to 0x10 is pending (ihit 3 cycles later) -> state DRAIN; imem_addr stays 0x10 until ihit; that response is not pushed; next request is 0x200; ifid_valid = 0 until 0x200 returns.
- Redirect to 0x300 in the same cycle as ihit -> response dropped; no DRAIN; next imem_addr = 0x300.
- RST asserted mid-request -> imem_ren = 0 and ifid_valid = 0 immediately; after release the first imem_addr = RESET_PC; with FETCH_PERF_EN, both counters read 0.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared types for the fetch PC unit: FSM state, fetch packet layout and
// the sequential PC step. Optional build macro used by the top: FETCH_PERF_EN.
package fetch_pkg;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } fetch_packet_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Bus bundle between the fetch PC unit and its neighbours (instruction
// memory, branch predictor, resolution stage, IF/ID latch).
//
// Handshake rules: a read request is imem_ren with imem_addr; once raised,
// both hold unchanged until the cycle imem_ihit is high, which completes
// the request (imem_rdata valid in that same cycle). At most one request is
// outstanding. The IF/ID head packet transfers in any cycle where
// ifid_valid is high and dec_stall is low.
interface fetch_pc_unit_if;
    import fetch_pkg::*;

    logic         imem_ren;
    logic [31:0]  imem_addr;
    logic         imem_ihit;
    logic [31:0]  imem_rdata;
    logic [31:0]  pc_fetch;
    logic [31:0]  pred_nxt_pc;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         dec_stall;
    logic         ifid_valid;
    logic [31:0]  ifid_instr;
    logic [31:0]  ifid_pc;
    logic         ifid_pred_taken;
    logic [31:0]  ifid_pred_target;
    fetch_state_t state_dbg;

    modport master (
        output imem_ren, imem_addr, pc_fetch,
        output ifid_valid, ifid_instr, ifid_pc, ifid_pred_taken, ifid_pred_target,
        output state_dbg,
        input  imem_ihit, imem_rdata, pred_nxt_pc, redirect, redirect_pc, dec_stall
    );

    modport slave (
        input  imem_ren, imem_addr, pc_fetch,
        input  ifid_valid, ifid_instr, ifid_pc, ifid_pred_taken, ifid_pred_target,
        input  state_dbg,
        output imem_ihit, imem_rdata, pred_nxt_pc, redirect, redirect_pc, dec_stall
    );

endinterface

// File: rtl/fetch_pc_unit_queue.sv
// Circular fetch-packet FIFO. Pointers wrap naturally (DEPTH is a power of
// two); flush empties it in one cycle and wins over push/pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_packet_t push_data,
    output fetch_packet_t head,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_CNT = DEPTH[PW:0];

    fetch_packet_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == DEPTH_CNT);
    assign empty   = (cnt == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    // Packet storage; contents are only visible while the queue is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC owner: issues one imem read at a time, pairs each response
// with the predictor's next PC and queues the packet for IF/ID. Redirects
// flush the queue; a request still in flight is drained and discarded.
// Optional build macro FETCH_PERF_EN adds redirect / decode-stall counters.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    fetch_pc_unit_if.master  bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_redirects,
    output logic [31:0]      perf_stall_cycles
`endif
);

    fetch_state_t  state;
    logic [31:0]   pc;
    logic [31:0]   drain_addr;
    logic          ren;
    logic          accept;
    logic          pop;
    logic          q_full;
    logic          q_empty;
    logic          valid;
    fetch_packet_t push_pkt;
    fetch_packet_t head;

    // A RUN request is only raised when the queue has room, so the response
    // always fits; DRAIN keeps the stale request alive until it completes.
    assign ren    = !RST && ((state == DRAIN) || !q_full);
    assign accept = (state == RUN) && ren && bus.imem_ihit && !bus.redirect;
    assign valid  = !q_empty;
    assign pop    = valid && !bus.dec_stall && !bus.redirect;

    assign push_pkt.instr       = bus.imem_rdata;
    assign push_pkt.pc          = pc;
    assign push_pkt.pred_taken  = (bus.pred_nxt_pc != pc + PC_STEP);
    assign push_pkt.pred_target = bus.pred_nxt_pc;

    fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
        .clk       (CLK),
        .rst       (RST),
        .push      (accept),
        .pop       (pop),
        .flush     (bus.redirect),
        .push_data (push_pkt),
        .head      (head),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign bus.imem_ren         = ren;
    assign bus.imem_addr        = (state == DRAIN) ? drain_addr : pc;
    assign bus.pc_fetch         = pc;
    assign bus.ifid_valid       = valid;
    assign bus.ifid_instr       = valid ? head.instr       : '0;
    assign bus.ifid_pc          = valid ? head.pc          : '0;
    assign bus.ifid_pred_taken  = valid ? head.pred_taken  : 1'b0;
    assign bus.ifid_pred_target = valid ? head.pred_target : '0;
    assign bus.state_dbg        = state;

    // PC / drain FSM: redirect has top priority, then response handling.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= RUN;
            pc         <= RESET_PC;
            drain_addr <= '0;
        end else if (bus.redirect) begin
            pc <= word_align(bus.redirect_pc);
            if (ren && !bus.imem_ihit) begin
                state <= DRAIN;
                if (state == RUN) drain_addr <= pc;
            end else begin
                state <= RUN;
            end
        end else begin
            case (state)
                RUN:     if (accept) pc <= bus.pred_nxt_pc;
                DRAIN:   if (bus.imem_ihit) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating event counters for redirects and decode back-pressure.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_redirects    <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (bus.redirect && (perf_redirects != 32'hFFFF_FFFF))
                perf_redirects <= perf_redirects + 32'd1;
            if (valid && bus.dec_stall && (perf_stall_cycles != 32'hFFFF_FFFF))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: scripted imem responder, predictor model,
// request/pop monitor against hand-written expected queues.
module tb_fetch_pc_unit;
    import fetch_pkg::*;

    localparam logic [31:0] KEY = 32'hC0DE_0000;

    logic clk;
    logic rst;
    fetch_pc_unit_if bus();
`ifdef FETCH_PERF_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_stall_cycles;
`endif

    fetch_pc_unit #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(2)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_redirects    (perf_redirects),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [31:0]   exp_addr_q[$];
    fetch_packet_t exp_q[$];

    int          budget = 0;
    int          lat = 1;
    int          wait_cnt = 0;
    logic        ov_en = 1'b0;
    logic [31:0] ov_pc = '0;
    logic [31:0] ov_tgt = '0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic exp_pkt(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        fetch_packet_t p;
        p.instr       = pc ^ KEY;
        p.pc          = pc;
        p.pred_taken  = taken;
        p.pred_target = tgt;
        exp_q.push_back(p);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (!(exp_q.size() == 0 && budget == 0) && n < max_cyc) begin
            cycle();
            n++;
        end
        check("idle_reached", 32'((exp_q.size() == 0) && (budget == 0)), 32'd1);
    endtask

    task automatic do_reset();
        check("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
        rst = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.dec_stall = 1'b0;
        budget = 0;
        lat = 1;
        ov_en = 1'b0;
        #1;
        check("rst_ren_now", 32'(bus.imem_ren), 32'd0);
        cycle();
        cycle();
        check("rst_ren", 32'(bus.imem_ren), 32'd0);
        check("rst_ifid_valid", 32'(bus.ifid_valid), 32'd0);
        check("rst_ifid_instr", bus.ifid_instr, 32'd0);
        check("rst_ifid_pc", bus.ifid_pc, 32'd0);
        check("rst_ifid_taken", 32'(bus.ifid_pred_taken), 32'd0);
        check("rst_ifid_target", bus.ifid_pred_target, 32'd0);
        check("rst_pc_fetch", bus.pc_fetch, 32'h0000_0000);
        check("rst_state", 32'(bus.state_dbg), 32'(RUN));
`ifdef FETCH_PERF_EN
        check("rst_perf_redirects", perf_redirects, 32'd0);
        check("rst_perf_stalls", perf_stall_cycles, 32'd0);
`endif
        exp_q.delete();
        exp_addr_q.delete();
    endtask

    // predictor model: sequential unless an override target is armed
    always_comb begin
        bus.pred_nxt_pc = bus.pc_fetch + 32'd4;
        if (ov_en && (bus.pc_fetch == ov_pc)) bus.pred_nxt_pc = ov_tgt;
    end

    // imem responder: answers after lat counted cycles while budget remains
    initial begin
        bus.imem_ihit = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                bus.imem_ihit = 1'b0;
                wait_cnt = 0;
            end else if (bus.imem_ihit) begin
                bus.imem_ihit = 1'b0;
                wait_cnt = (bus.imem_ren && budget > 0) ? 1 : 0;
            end else if (bus.imem_ren && budget > 0) begin
                if (wait_cnt >= lat) begin
                    bus.imem_ihit = 1'b1;
                    bus.imem_rdata = bus.imem_addr ^ KEY;
                    budget--;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // monitor: request starts, address hold, and IF/ID pops vs scoreboard
    initial begin
        logic        pend;
        logic [31:0] held;
        fetch_packet_t e;
        pend = 1'b0;
        held = '0;
        forever begin
            @(posedge clk);
            #3;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (bus.imem_ren) begin
                    if (!pend) begin
                        check("req_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                        if (exp_addr_q.size() != 0)
                            check("req_addr", bus.imem_addr, exp_addr_q.pop_front());
                        held = bus.imem_addr;
                    end else begin
                        check("addr_hold", bus.imem_addr, held);
                    end
                end else if (pend) begin
                    check("ren_hold", 32'(bus.imem_ren), 32'd1);
                end
                pend = bus.imem_ren && !bus.imem_ihit;
                if (bus.ifid_valid && !bus.dec_stall && !bus.redirect) begin
                    check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("pop_pc", bus.ifid_pc, e.pc);
                        check("pop_instr", bus.ifid_instr, e.instr);
                        check("pop_taken", 32'(bus.ifid_pred_taken), 32'(e.pred_taken));
                        check("pop_target", bus.ifid_pred_target, e.pred_target);
                    end
                end
            end
        end
    end

    // directed phases
    initial begin
        int n;
        rst = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.dec_stall = 1'b0;

        // sequential fetch 0,4,8
        do_reset();
        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_pkt(32'h0, 1'b0, 32'h4);
        exp_pkt(32'h4, 1'b0, 32'h8);
        exp_pkt(32'h8, 1'b0, 32'hC);
        budget = 3;
        rst = 1'b0;
        wait_idle(60);
        cycle();
        check("p1_ren", 32'(bus.imem_ren), 32'd1);
        check("p1_addr", bus.imem_addr, 32'hC);
        check("p1_ifid_valid", 32'(bus.ifid_valid), 32'd0);

        // redirect to 0x40 over a pending request, then a taken prediction
        do_reset();
        exp_addr_q = '{32'h0, 32'h40, 32'h100, 32'h104};
        exp_pkt(32'h40, 1'b1, 32'h100);
        exp_pkt(32'h100, 1'b0, 32'h104);
        ov_en = 1'b1;
        ov_pc = 32'h40;
        ov_tgt = 32'h100;
        rst = 1'b0;
        cycle();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h40;
        cycle();
        bus.redirect = 1'b0;
        check("p2_state", 32'(bus.state_dbg), 32'(DRAIN));
        check("p2_drain_addr", bus.imem_addr, 32'h0);
        check("p2_pc_fetch", bus.pc_fetch, 32'h40);
        budget = 3;
        wait_idle(60);
        cycle();
        check("p2_addr", bus.imem_addr, 32'h104);
        check("p2_state_run", 32'(bus.state_dbg), 32'(RUN));

        // decode stall fills the queue and stops requests
        do_reset();
        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_pkt(32'h0, 1'b0, 32'h4);
        exp_pkt(32'h4, 1'b0, 32'h8);
        exp_pkt(32'h8, 1'b0, 32'hC);
        bus.dec_stall = 1'b1;
        budget = 3;
        rst = 1'b0;
        repeat (8) cycle();
        check("p3_full_valid", 32'(bus.ifid_valid), 32'd1);
        check("p3_full_head", bus.ifid_pc, 32'h0);
        check("p3_full_instr", bus.ifid_instr, 32'h0 ^ KEY);
        check("p3_full_ren", 32'(bus.imem_ren), 32'd0);
        bus.dec_stall = 1'b0;
        wait_idle(60);
        cycle();
        check("p3_addr", bus.imem_addr, 32'hC);

        // redirect to 0x200 while the 0x10 request is pending
        do_reset();
        exp_addr_q = '{32'h0, 32'h10, 32'h200, 32'h204};
        exp_pkt(32'h0, 1'b1, 32'h10);
        exp_pkt(32'h200, 1'b0, 32'h204);
        ov_en = 1'b1;
        ov_pc = 32'h0;
        ov_tgt = 32'h10;
        budget = 1;
        rst = 1'b0;
        n = 0;
        while (exp_q.size() != 1 && n < 30) begin
            cycle();
            n++;
        end
        check("p4_first_pop", 32'(exp_q.size()), 32'd1);
        repeat (2) cycle();
        check("p4_pending_addr", bus.imem_addr, 32'h10);
        check("p4_pending_ren", 32'(bus.imem_ren), 32'd1);
        lat = 3;
        budget = 2;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h200;
        cycle();
        bus.redirect = 1'b0;
        check("p4_state", 32'(bus.state_dbg), 32'(DRAIN));
        check("p4_drain_addr", bus.imem_addr, 32'h10);
        check("p4_pc_fetch", bus.pc_fetch, 32'h200);
        n = 0;
        while (!bus.imem_ihit && n < 10) begin
            check("p4_drain_valid", 32'(bus.ifid_valid), 32'd0);
            check("p4_drain_hold", bus.imem_addr, 32'h10);
            cycle();
            n++;
        end
        check("p4_drain_ihit", 32'(bus.imem_ihit), 32'd1);
        wait_idle(60);
        cycle();
        check("p4_addr", bus.imem_addr, 32'h204);

        // redirect (misaligned 0x302) in the same cycle as ihit
        do_reset();
        exp_addr_q = '{32'h0, 32'h300, 32'h304};
        budget = 2;
        rst = 1'b0;
        n = 0;
        while (!bus.imem_ihit && n < 10) begin
            cycle();
            n++;
        end
        check("p5_ihit_seen", 32'(bus.imem_ihit), 32'd1);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h302;
        bus.dec_stall = 1'b1;
        cycle();
        bus.redirect = 1'b0;
        check("p5_state", 32'(bus.state_dbg), 32'(RUN));
        check("p5_addr", bus.imem_addr, 32'h300);
        check("p5_pc_fetch", bus.pc_fetch, 32'h300);
        check("p5_dropped", 32'(bus.ifid_valid), 32'd0);
        n = 0;
        while (!bus.ifid_valid && n < 10) begin
            cycle();
            n++;
        end
        check("p5_head_valid", 32'(bus.ifid_valid), 32'd1);
        check("p5_head_pc", bus.ifid_pc, 32'h300);
        check("p5_head_instr", bus.ifid_instr, 32'h300 ^ KEY);
        check("p5_head_taken", 32'(bus.ifid_pred_taken), 32'd0);
        check("p5_head_target", bus.ifid_pred_target, 32'h304);
        repeat (2) cycle();
        check("p5_next_addr", bus.imem_addr, 32'h304);
        check("p5_next_ren", 32'(bus.imem_ren), 32'd1);

        // reset in the middle of a pending request
        rst = 1'b1;
        #1;
        check("p6_ren_now", 32'(bus.imem_ren), 32'd0);
        check("p6_valid_now", 32'(bus.ifid_valid), 32'd0);
        cycle();
        cycle();
        check("p6_pc_fetch", bus.pc_fetch, 32'h0);
`ifdef FETCH_PERF_EN
        check("p6_perf_redirects", perf_redirects, 32'd0);
        check("p6_perf_stalls", perf_stall_cycles, 32'd0);
`endif
        bus.dec_stall = 1'b0;
        exp_addr_q.delete();
        exp_addr_q.push_back(32'h0);
        rst = 1'b0;
        cycle();
        check("p6_ren", 32'(bus.imem_ren), 32'd1);
        check("p6_addr", bus.imem_addr, 32'h0);
        cycle();

        check("end_addr_q", 32'(exp_addr_q.size()), 32'd0);
        check("end_pkt_q", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
